// File: rtl/catraca_tarifada.sv
// Coin-operated turnstile: collects PRICE coins to unlock the arm, counts
// passages, raises an alarm on forced pushes and relocks after a dwell timeout.
module catraca_tarifada #(
    parameter int unsigned PRICE    = 3,
    parameter int unsigned TIMEOUT  = 16,
    parameter int unsigned CNT_W    = 8,
    localparam int unsigned CREDIT_W = $clog2(PRICE + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                coin_i,
    input  logic                push_i,
    input  logic                ack_i,
    input  logic                cnt_clr_i,
    output logic                locked_o,
    output logic                unlocked_o,
    output logic                alarm_o,
    output logic [CREDIT_W-1:0] credit_o,
    output logic [CNT_W-1:0]    counter_o,
    output logic                reject_o,
    output logic                timeout_o,
    output logic [1:0]          state_dbg_o
);

    // Inputs are level samples taken on every rising edge; there is no
    // valid/ready handshake: a coin or push is consumed in the cycle it is seen.

    typedef enum logic [1:0] {
        S_LOCKED   = 2'd0,
        S_PAYING   = 2'd1,
        S_UNLOCKED = 2'd2,
        S_ALARM    = 2'd3
    } state_t;

    localparam int unsigned TIMER_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    // Credit value that, plus the incoming coin, completes the fare.
    localparam logic [CREDIT_W-1:0] PRICE_LAST = CREDIT_W'(PRICE - 1);
    localparam logic [TIMER_W-1:0]  TIMER_LAST = TIMER_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic [CNT_W-1:0]    CNT_MAX    = '1;

    state_t              state_q,   state_d;
    logic [CREDIT_W-1:0] credit_q,  credit_d;
    logic [CNT_W-1:0]    counter_q, counter_d;
    logic [TIMER_W-1:0]  timer_q,   timer_d;
    logic                reject_q,  reject_d;
    logic                timeout_q, timeout_d;
    logic                passage;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_LOCKED;
            credit_q  <= '0;
            counter_q <= '0;
            timer_q   <= '0;
            reject_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            credit_q  <= credit_d;
            counter_q <= counter_d;
            timer_q   <= timer_d;
            reject_q  <= reject_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        credit_d  = credit_q;
        timer_d   = '0;
        reject_d  = 1'b0;
        timeout_d = 1'b0;
        passage   = 1'b0;

        case (state_q)
            S_LOCKED, S_PAYING: begin
                if (push_i) begin
                    // A push on a locked arm is forced entry: drop the fare.
                    state_d  = S_ALARM;
                    credit_d = '0;
                    reject_d = coin_i;
                end else if (coin_i) begin
                    if (credit_q == PRICE_LAST) begin
                        state_d  = S_UNLOCKED;
                        credit_d = '0;
                    end else begin
                        state_d  = S_PAYING;
                        credit_d = credit_q + 1'b1;
                    end
                end
            end

            S_UNLOCKED: begin
                reject_d = coin_i;
                if (push_i) begin
                    state_d = S_LOCKED;
                    passage = 1'b1;
                end else if ((TIMEOUT > 0) && (timer_q == TIMER_LAST)) begin
                    state_d   = S_LOCKED;
                    timeout_d = 1'b1;
                end else begin
                    // The default of zero covers entry; only staying increments.
                    timer_d = timer_q + 1'b1;
                end
            end

            S_ALARM: begin
                reject_d = coin_i;
                if (ack_i) begin
                    state_d = S_LOCKED;
                end
            end

            default: begin
                state_d  = S_LOCKED;
                credit_d = '0;
            end
        endcase
    end

    // Clear wins over a simultaneous passage; the count sticks at all ones.
    always_comb begin
        counter_d = counter_q;
        if (cnt_clr_i) begin
            counter_d = '0;
        end else if (passage && (counter_q != CNT_MAX)) begin
            counter_d = counter_q + 1'b1;
        end
    end

    assign locked_o    = (state_q == S_LOCKED) || (state_q == S_PAYING);
    assign unlocked_o  = (state_q == S_UNLOCKED);
    assign alarm_o     = (state_q == S_ALARM);
    assign credit_o    = credit_q;
    assign counter_o   = counter_q;
    assign reject_o    = reject_q;
    assign timeout_o   = timeout_q;
    assign state_dbg_o = state_q;

endmodule

// File: tb/tb_catraca_tarifada.sv
// Directed bench for catraca_tarifada (PRICE=3, TIMEOUT=8, CNT_W=4): a vector
// table for single-cycle behaviour plus hand sequences for multi-cycle cases.
module tb_catraca_tarifada;

    logic       clk;
    logic       rst_n;
    logic       coin_i, push_i, ack_i, cnt_clr_i;
    logic       locked_o, unlocked_o, alarm_o;
    logic [1:0] credit_o;
    logic [3:0] counter_o;
    logic       reject_o, timeout_o;
    logic [1:0] state_dbg_o;

    int errors = 0;
    int checks = 0;

    catraca_tarifada #(
        .PRICE   (3),
        .TIMEOUT (8),
        .CNT_W   (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .coin_i      (coin_i),
        .push_i      (push_i),
        .ack_i       (ack_i),
        .cnt_clr_i   (cnt_clr_i),
        .locked_o    (locked_o),
        .unlocked_o  (unlocked_o),
        .alarm_o     (alarm_o),
        .credit_o    (credit_o),
        .counter_o   (counter_o),
        .reject_o    (reject_o),
        .timeout_o   (timeout_o),
        .state_dbg_o (state_dbg_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       coin, push, ack, clr;
        logic       lk, ul, al;
        logic [1:0] cr;
        logic [3:0] cnt;
        logic       rej, to;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic coin, push, ack, clr,
                                input logic lk, ul, al, input logic [1:0] cr,
                                input logic [3:0] cnt, input logic rej, to);
        vec_t v;
        v.coin = coin; v.push = push; v.ack = ack; v.clr = clr;
        v.lk = lk; v.ul = ul; v.al = al; v.cr = cr; v.cnt = cnt;
        v.rej = rej; v.to = to;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called at a negedge: drive inputs, return at the next negedge.
    task automatic step(input logic c, p, a, clr);
        coin_i = c; push_i = p; ack_i = a; cnt_clr_i = clr;
        @(negedge clk);
        coin_i = 1'b0; push_i = 1'b0; ack_i = 1'b0; cnt_clr_i = 1'b0;
    endtask

    task automatic pay_and_pass();
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_ul;
        int n_to;

        // coin push ack clr | lk ul al cr cnt rej to
        add(1,0,0,0, 1,0,0,1,0,0,0);
        add(1,0,0,0, 1,0,0,2,0,0,0);
        add(1,0,0,0, 0,1,0,0,0,0,0);
        add(0,1,0,0, 1,0,0,0,1,0,0);
        // push with coin while paying: alarm, coin refused
        add(1,0,0,0, 1,0,0,1,1,0,0);
        add(1,1,0,0, 0,0,1,0,1,1,0);
        add(1,1,0,0, 0,0,1,0,1,1,0);
        add(0,0,1,0, 1,0,0,0,1,0,0);
        // coin while unlocked is refused
        add(1,0,0,0, 1,0,0,1,1,0,0);
        add(1,0,0,0, 1,0,0,2,1,0,0);
        add(1,0,0,0, 0,1,0,0,1,0,0);
        add(1,0,0,0, 0,1,0,0,1,1,0);
        add(0,1,0,0, 1,0,0,0,2,0,0);
        // push in the 8th unlocked cycle beats the timeout
        add(1,0,0,0, 1,0,0,1,2,0,0);
        add(1,0,0,0, 1,0,0,2,2,0,0);
        add(1,0,0,0, 0,1,0,0,2,0,0);
        for (int k = 0; k < 7; k++) add(0,0,0,0, 0,1,0,0,2,0,0);
        add(0,1,0,0, 1,0,0,0,3,0,0);
        // no push: relock after 8 cycles with one timeout pulse
        add(1,0,0,0, 1,0,0,1,3,0,0);
        add(1,0,0,0, 1,0,0,2,3,0,0);
        add(1,0,0,0, 0,1,0,0,3,0,0);
        for (int k = 0; k < 7; k++) add(0,0,0,0, 0,1,0,0,3,0,0);
        add(0,0,0,0, 1,0,0,0,3,0,1);
        add(0,0,0,0, 1,0,0,0,3,0,0);
        // clear beats a simultaneous passage
        add(1,0,0,0, 1,0,0,1,3,0,0);
        add(1,0,0,0, 1,0,0,2,3,0,0);
        add(1,0,0,0, 0,1,0,0,3,0,0);
        add(0,1,0,1, 1,0,0,0,0,0,0);
        // push on a locked arm, then ack with push ignored
        add(0,1,0,0, 0,0,1,0,0,0,0);
        add(0,1,1,0, 1,0,0,0,0,0,0);
        // coin with push while unlocked: passage counted, coin refused
        add(1,0,0,0, 1,0,0,1,0,0,0);
        add(1,0,0,0, 1,0,0,2,0,0,0);
        add(1,0,0,0, 0,1,0,0,0,0,0);
        add(1,1,0,0, 1,0,0,0,1,1,0);

        rst_n = 1'b0;
        coin_i = 1'b0; push_i = 1'b0; ack_i = 1'b0; cnt_clr_i = 1'b0;
        #1;
        chk("rst locked",   locked_o,   1);
        chk("rst unlocked", unlocked_o, 0);
        chk("rst alarm",    alarm_o,    0);
        chk("rst credit",   credit_o,   0);
        chk("rst counter",  counter_o,  0);
        chk("rst reject",   reject_o,   0);
        chk("rst timeout",  timeout_o,  0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].coin, vecs[i].push, vecs[i].ack, vecs[i].clr);
            chk($sformatf("v%0d locked", i),   locked_o,   vecs[i].lk);
            chk($sformatf("v%0d unlocked", i), unlocked_o, vecs[i].ul);
            chk($sformatf("v%0d alarm", i),    alarm_o,    vecs[i].al);
            chk($sformatf("v%0d credit", i),   credit_o,   vecs[i].cr);
            chk($sformatf("v%0d counter", i),  counter_o,  vecs[i].cnt);
            chk($sformatf("v%0d reject", i),   reject_o,   vecs[i].rej);
            chk($sformatf("v%0d timeout", i),  timeout_o,  vecs[i].to);
        end

        // Dwell window measured over a bounded number of cycles.
        n_ul = 0;
        n_to = 0;
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        for (int k = 0; k < 40; k++) begin
            if (unlocked_o) n_ul++;
            if (timeout_o)  n_to++;
            step(0, 0, 0, 0);
        end
        chk("dwell unlocked cycles", n_ul, 8);
        chk("dwell timeout pulses",  n_to, 1);
        chk("dwell counter",         counter_o, 1);
        chk("dwell locked",          locked_o, 1);

        // Saturation of the 4-bit passage counter.
        step(0, 0, 0, 1);
        chk("sat clear", counter_o, 0);
        for (int k = 0; k < 15; k++) pay_and_pass();
        chk("sat at 15", counter_o, 15);
        pay_and_pass();
        pay_and_pass();
        chk("sat after 17", counter_o, 15);
        step(0, 0, 0, 1);
        chk("sat cleared", counter_o, 0);

        // Reset mid-payment acts immediately and discards credit.
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("midpay credit", credit_o, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("midpay rst credit", credit_o, 0);
        chk("midpay rst locked", locked_o, 1);
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 0, 0, 0);
        chk("repay 1 credit", credit_o, 1);
        step(1, 0, 0, 0);
        chk("repay 2 locked", locked_o, 1);
        chk("repay 2 credit", credit_o, 2);
        step(1, 0, 0, 0);
        chk("repay 3 unlocked", unlocked_o, 1);
        chk("repay 3 credit",   credit_o, 0);

        // Reset while in alarm clears it without a pulse.
        step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        chk("pre rst alarm", alarm_o, 1);
        chk("pre rst reject", reject_o, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("alarm rst alarm",  alarm_o,  0);
        chk("alarm rst locked", locked_o, 1);
        chk("alarm rst reject", reject_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 0, 0);
        chk("post rst locked", locked_o, 1);
        chk("post rst timeout", timeout_o, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
